// File: rtl/cp0_vectored_intc_if.sv
// CP0 exception controller bus: exception requests, ERET,
// mfc0/mtc0 access and the next-PC redirect back to the fetch stage.
interface cp0_vectored_intc_if #(
    parameter int NUM_SRC = 3
) ();
    logic [NUM_SRC-1:0] exp_src;
    logic               exp_block;
    logic               is_eret;
    logic [31:0]        pc_in;
    logic               cp0_en;
    logic               cp0_wr;
    logic [4:0]         cp0_addr;
    logic [31:0]        cp0_wdata;
    logic [31:0]        cp0_rdata;
    logic               has_exp;
    logic [31:0]        pc_out;
    logic               stack_full;
    logic               eret_err;
    logic [31:0]        taken_count;

    modport master (
        output exp_src, exp_block, is_eret, pc_in,
        output cp0_en, cp0_wr, cp0_addr, cp0_wdata,
        input  cp0_rdata, has_exp, pc_out,
        input  stack_full, eret_err, taken_count
    );

    modport slave (
        input  exp_src, exp_block, is_eret, pc_in,
        input  cp0_en, cp0_wr, cp0_addr, cp0_wdata,
        output cp0_rdata, has_exp, pc_out,
        output stack_full, eret_err, taken_count
    );
endinterface

// File: rtl/cp0_vectored_intc.sv
// Vectored, nestable CP0 exception controller: edge-latched sources,
// fixed priority, EPC stack and STATUS/CAUSE/EPC register access.
module cp0_vectored_intc #(
    parameter int          NUM_SRC     = 3,
    parameter int          STACK_DEPTH = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010
) (
    input logic               clk,
    input logic               rst,
    cp0_vectored_intc_if.slave bus
);
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;
    localparam int WW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] mask;
    logic               ie;
    logic               eret_err_q;
    logic [31:0]        taken_q;
    logic [SPW-1:0]     sp;
    logic [31:0]        stack [STACK_DEPTH];

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] isr_oh;
    logic [WW-1:0]      win;
    logic               blocked;
    logic               full;
    logic               empty;
    logic               take;
    logic               pop;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      top_idx;
    logic [31:0]        top_val;
    logic [31:0]        vec_addr;
    logic               wr_en;

    assign edge_det = bus.exp_src & ~prev_src;
    assign full     = (sp == SPW'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign push_idx = sp[IW-1:0];
    assign top_idx  = push_idx - IW'(1);
    assign top_val  = empty ? 32'd0 : stack[top_idx];
    assign wr_en    = bus.cp0_en & bus.cp0_wr;

    // A source may only preempt levels of strictly lower priority.
    always_comb begin
        elig    = '0;
        blocked = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            blocked = blocked | in_service[i];
            elig[i] = pending[i] & mask[i] & ~blocked;
        end
    end

    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win = WW'(i);
        end
    end

    assign take = ie & ~bus.exp_block & ~bus.is_eret
                & ~full & (|elig);
    assign pop  = bus.is_eret & ~empty;

    assign win_oh   = take ? (elig & (~elig + NUM_SRC'(1))) : '0;
    assign isr_oh   = pop ? (in_service & (~in_service + NUM_SRC'(1)))
                          : '0;
    assign vec_addr = VEC_BASE + (32'(win) * VEC_STRIDE);

    assign bus.has_exp     = take & ~rst;
    assign bus.stack_full  = full;
    assign bus.eret_err    = eret_err_q;
    assign bus.taken_count = taken_q;

    always_comb begin
        bus.pc_out = 32'd0;
        if (!rst) begin
            if (take)     bus.pc_out = vec_addr;
            else if (pop) bus.pc_out = top_val;
        end
    end

    always_comb begin
        bus.cp0_rdata = 32'd0;
        if (bus.cp0_en && !rst) begin
            unique case (1'b1)
                bus.cp0_addr == A_STATUS:
                    bus.cp0_rdata = 32'({mask, ie});
                bus.cp0_addr == A_CAUSE:
                    bus.cp0_rdata = (32'(in_service) << 16)
                                  | 32'(pending);
                bus.cp0_addr == A_EPC:
                    bus.cp0_rdata = top_val;
                default:
                    bus.cp0_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            prev_src   <= '0;
            mask       <= '0;
            ie         <= 1'b0;
            eret_err_q <= 1'b0;
            taken_q    <= 32'd0;
            sp         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 32'd0;
        end else begin
            prev_src   <= bus.exp_src;
            // A fresh edge on the winning source keeps it pending.
            pending    <= (pending & ~win_oh) | edge_det;
            in_service <= (in_service | win_oh) & ~isr_oh;
            if (take) begin
                stack[push_idx] <= bus.pc_in;
                sp              <= sp + SPW'(1);
                taken_q         <= taken_q + 32'd1;
            end else if (pop) begin
                sp <= sp - SPW'(1);
            end
            if (bus.is_eret && empty) eret_err_q <= 1'b1;
            if (wr_en && bus.cp0_addr == A_STATUS) begin
                ie   <= bus.cp0_wdata[0];
                mask <= bus.cp0_wdata[NUM_SRC:1];
            end
            if (wr_en && bus.cp0_addr == A_EPC && !empty)
                stack[top_idx] <= bus.cp0_wdata;
        end
    end
endmodule
